// File: rtl/icap_pkg.sv
// Shared constants, state type and byte bit-reversal helper for the
// Spartan-6 MultiBoot ICAP controller.
package icap_pkg;

  localparam logic [15:0] SYNC0     = 16'hAA99;
  localparam logic [15:0] SYNC1     = 16'h5566;
  localparam logic [15:0] HDR_GEN1  = 16'h3261;
  localparam logic [15:0] HDR_GEN2  = 16'h3281;
  localparam logic [15:0] HDR_GEN3  = 16'h32A1;
  localparam logic [15:0] HDR_GEN4  = 16'h32C1;
  localparam logic [15:0] HDR_CMD   = 16'h30A1;
  localparam logic [15:0] CMD_IPROG = 16'h000E;
  localparam logic [15:0] NOOP      = 16'h2000;
  localparam logic [15:0] DUMMY     = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_HOLDOFF,
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  // ICAP_SPARTAN6 expects each byte bit-reversed relative to the bitstream.
  function automatic logic [15:0] bitswap16(input logic [15:0] w);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i]     = w[7 - i];
      r[8 + i] = w[15 - i];
    end
    return r;
  endfunction

endpackage

// File: rtl/icap_seq_rom.sv
// Combinational lookup of the IPROG word sequence. When the fallback
// registers are disabled the GENERAL3/4 entries are skipped, so indices
// from 6 upward are shifted past them.
module icap_seq_rom
  import icap_pkg::*;
#(
  parameter bit          FALLBACK_EN = 1'b1,
  parameter logic [7:0]  READ_OP     = 8'h03,
  parameter logic [23:0] GOLDEN_ADDR = 24'h000000
) (
  input  logic [3:0]  index,
  input  logic [23:0] addr,
  output logic [15:0] data
);

  logic [3:0] pos;

  // Map the running index onto the full 16-entry list and select the word.
  always_comb begin
    pos = index;
    if (!FALLBACK_EN && index >= 4'd6) begin
      pos = index + 4'd4;
    end
    data = NOOP;
    case (pos)
      4'd0:    data = SYNC0;
      4'd1:    data = SYNC1;
      4'd2:    data = HDR_GEN1;
      4'd3:    data = addr[15:0];
      4'd4:    data = HDR_GEN2;
      4'd5:    data = {READ_OP, addr[23:16]};
      4'd6:    data = HDR_GEN3;
      4'd7:    data = GOLDEN_ADDR[15:0];
      4'd8:    data = HDR_GEN4;
      4'd9:    data = {READ_OP, GOLDEN_ADDR[23:16]};
      4'd10:   data = HDR_CMD;
      4'd11:   data = CMD_IPROG;
      default: data = NOOP;
    endcase
  end

endmodule

// File: rtl/icap_multiboot_ctrl.sv
// MultiBoot controller: after a startup holdoff, accepts a slot request,
// computes the flash start address and streams the IPROG sequence to ICAP.
module icap_multiboot_ctrl
  import icap_pkg::*;
#(
  parameter int          NUM_IMAGES    = 8,
  parameter logic [23:0] IMAGE_BASE    = 24'h054000,
  parameter logic [23:0] IMAGE_STRIDE  = 24'h054000,
  parameter logic [7:0]  READ_OP       = 8'h03,
  parameter bit          FALLBACK_EN   = 1'b1,
  parameter logic [23:0] GOLDEN_ADDR   = 24'h000000,
  parameter int          STARTUP_DELAY = 15,
  parameter bit          BIT_SWAP      = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [3:0]  slot,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        icap_ce_n,
  output logic        icap_wr_n,
  output logic [15:0] icap_din
);

  localparam int              HOLD_W     = $clog2(STARTUP_DELAY + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(STARTUP_DELAY - 1);
  localparam logic [4:0]      WORD_COUNT = FALLBACK_EN ? 5'd16 : 5'd12;
  localparam logic [4:0]      NUM_SLOTS  = 5'(NUM_IMAGES);

  state_t              state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [4:0]          word_idx;
  logic [23:0]         addr;
  logic [27:0]         slot_offset;
  logic [23:0]         slot_addr;
  logic [15:0]         rom_data;
  logic [15:0]         out_word;

  // Slot address uses a 28-bit product; the sum wraps to the 24-bit flash space.
  assign slot_offset = 28'(slot) * 28'(IMAGE_STRIDE);
  assign slot_addr   = 24'(28'(IMAGE_BASE) + slot_offset);

  icap_seq_rom #(
    .FALLBACK_EN (FALLBACK_EN),
    .READ_OP     (READ_OP),
    .GOLDEN_ADDR (GOLDEN_ADDR)
  ) u_rom (
    .index (word_idx[3:0]),
    .addr  (addr),
    .data  (rom_data)
  );

  // Apply the optional per-byte bit reversal before the word is registered.
  always_comb begin
    out_word = rom_data;
    if (BIT_SWAP) begin
      out_word = bitswap16(rom_data);
    end
  end

  // Main FSM: holdoff, request acceptance, word streaming and completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_HOLDOFF;
      hold_cnt  <= '0;
      word_idx  <= '0;
      addr      <= '0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      icap_ce_n <= 1'b1;
      icap_wr_n <= 1'b1;
      icap_din  <= DUMMY;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_HOLDOFF: begin
          if (hold_cnt == HOLD_LAST) begin
            ready <= 1'b1;
            state <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        ST_IDLE: begin
          if (req) begin
            if ({1'b0, slot} < NUM_SLOTS) begin
              addr     <= slot_addr;
              word_idx <= '0;
              busy     <= 1'b1;
              ready    <= 1'b0;
              state    <= ST_RUN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (word_idx == WORD_COUNT) begin
            icap_ce_n <= 1'b1;
            icap_wr_n <= 1'b1;
            icap_din  <= DUMMY;
            done      <= 1'b1;
            state     <= ST_DONE;
          end else begin
            icap_ce_n <= 1'b0;
            icap_wr_n <= 1'b0;
            icap_din  <= out_word;
            word_idx  <= word_idx + 5'd1;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          ready <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_HOLDOFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icap_multiboot_ctrl.sv
// Self-checking bench for icap_multiboot_ctrl: two instances (default
// fallback/bit-swapped build and a no-fallback 16-slot wrap build),
// table-driven vectors, hand-written corner sequences and random requests
// checked against a word-list model.
module tb_icap_multiboot_ctrl;

  localparam logic [23:0] A_BASE   = 24'h054000;
  localparam logic [23:0] A_STRIDE = 24'h054000;
  localparam int          A_NUM    = 8;
  localparam logic [23:0] B_BASE   = 24'h150000;
  localparam logic [23:0] B_STRIDE = 24'h100000;
  localparam int          B_NUM    = 16;
  localparam logic [7:0]  OP       = 8'h03;
  localparam logic [23:0] GOLDEN   = 24'h000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [3:0]  slot_a = '0, slot_b = '0;
  logic        ready_a, busy_a, done_a, err_a, ce_n_a, wr_n_a;
  logic        ready_b, busy_b, done_b, err_b, ce_n_b, wr_n_b;
  logic [15:0] din_a, din_b;

  logic        sel_b = 1'b0;
  logic        o_ready, o_busy, o_done, o_err, o_ce_n, o_wr_n;
  logic [15:0] o_din;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

  typedef struct {
    bit          use_b;
    logic [3:0]  slot;
    bit          exp_err;
    logic [23:0] exp_addr;
  } vec_t;

  vec_t vecs[8];

  icap_multiboot_ctrl dut_a (
    .clk (clk), .rst_n (rst_n), .req (req_a), .slot (slot_a),
    .ready (ready_a), .busy (busy_a), .done (done_a), .err (err_a),
    .icap_ce_n (ce_n_a), .icap_wr_n (wr_n_a), .icap_din (din_a)
  );

  icap_multiboot_ctrl #(
    .NUM_IMAGES (B_NUM), .IMAGE_BASE (B_BASE), .IMAGE_STRIDE (B_STRIDE),
    .READ_OP (OP), .FALLBACK_EN (1'b0), .GOLDEN_ADDR (GOLDEN),
    .STARTUP_DELAY (15), .BIT_SWAP (1'b0)
  ) dut_b (
    .clk (clk), .rst_n (rst_n), .req (req_b), .slot (slot_b),
    .ready (ready_b), .busy (busy_b), .done (done_b), .err (err_b),
    .icap_ce_n (ce_n_b), .icap_wr_n (wr_n_b), .icap_din (din_b)
  );

  always #5 clk = ~clk;

  // Route the selected instance's outputs to one set of observation signals.
  always_comb begin
    o_ready = sel_b ? ready_b : ready_a;
    o_busy  = sel_b ? busy_b  : busy_a;
    o_done  = sel_b ? done_b  : done_a;
    o_err   = sel_b ? err_b   : err_a;
    o_ce_n  = sel_b ? ce_n_b  : ce_n_a;
    o_wr_n  = sel_b ? wr_n_b  : wr_n_a;
    o_din   = sel_b ? din_b   : din_a;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [3:0] s);
    if (sel_b) begin
      req_b = r; slot_b = s;
    end else begin
      req_a = r; slot_a = s;
    end
  endtask

  function automatic logic [15:0] rev_bytes(input logic [15:0] w);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = w[(i / 8) * 8 + 7 - (i % 8)];
    return r;
  endfunction

  function automatic logic [23:0] model_addr(input bit b, input int s);
    longint base, stride;
    base   = b ? longint'(B_BASE) : longint'(A_BASE);
    stride = b ? longint'(B_STRIDE) : longint'(A_STRIDE);
    return 24'((base + longint'(s) * stride) % (longint'(1) << 24));
  endfunction

  task automatic build_seq(input bit fb, input logic [23:0] a);
    exp_q.delete();
    exp_q.push_back(16'hAA99);
    exp_q.push_back(16'h5566);
    exp_q.push_back(16'h3261);
    exp_q.push_back(a[15:0]);
    exp_q.push_back(16'h3281);
    exp_q.push_back({OP, a[23:16]});
    if (fb) begin
      exp_q.push_back(16'h32A1);
      exp_q.push_back(GOLDEN[15:0]);
      exp_q.push_back(16'h32C1);
      exp_q.push_back({OP, GOLDEN[23:16]});
    end
    exp_q.push_back(16'h30A1);
    exp_q.push_back(16'h000E);
    repeat (4) exp_q.push_back(16'h2000);
  endtask

  task automatic issue(input logic [3:0] s);
    int n;
    n = 0;
    while (!o_ready && n < 100) begin
      step();
      n++;
    end
    check("ready_before_req", {31'd0, o_ready}, 32'd1);
    drive(1'b1, s);
    step();
    drive(1'b0, 4'($urandom_range(0, 15)));
  endtask

  task automatic expect_run(input logic [23:0] a, input bit poke);
    bit sw;
    sw = !sel_b;
    build_seq(!sel_b, a);
    got_q.delete();
    check("accept_busy", {31'd0, o_busy}, 32'd1);
    check("accept_ready", {31'd0, o_ready}, 32'd0);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (poke && k == 3) drive(1'b1, 4'($urandom_range(0, 15)));
      if (poke && k == 8) drive(1'b0, 4'($urandom_range(0, 15)));
      step();
      got_q.push_back(o_din);
      check($sformatf("word%0d_din", k), {16'd0, o_din},
            {16'd0, sw ? rev_bytes(exp_q[k]) : exp_q[k]});
      check($sformatf("word%0d_strobes", k), {30'd0, o_ce_n, o_wr_n}, 32'd0);
      check($sformatf("word%0d_busy_done", k), {30'd0, o_busy, o_done}, 32'd2);
    end
    step();
    check("done_pulse", {30'd0, o_done, o_busy}, 32'd3);
    check("done_idle_bus", {14'd0, o_ce_n, o_wr_n, o_din}, {14'd0, 2'b11, 16'hFFFF});
    step();
    check("after_done", {29'd0, o_done, o_busy, o_ready}, 32'd1);
    check("after_done_ce", {31'd0, o_ce_n}, 32'd1);
  endtask

  task automatic expect_reject();
    check("reject_err", {31'd0, o_err}, 32'd1);
    check("reject_state", {29'd0, o_busy, o_ce_n, o_ready}, 32'd3);
    step();
    check("reject_err_clear", {30'd0, o_err, o_busy}, 32'd0);
    check("reject_ce", {31'd0, o_ce_n}, 32'd1);
  endtask

  task automatic holdoff_check();
    int bad;
    bad = 0;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (o_ready !== 1'b0 || o_ce_n !== 1'b1 || o_busy !== 1'b0) bad++;
    end
    check("holdoff_quiet_cycles", bad, 0);
    step();
    check("holdoff_ready_rise", {30'd0, o_ready, o_busy}, 32'd2);
  endtask

  task automatic applyStimulus();
    logic [15:0] lit_slot2[16];
    logic [3:0]  s;
    int          num;

    lit_slot2 = '{16'hAA99, 16'h5566, 16'h3261, 16'hC000, 16'h3281, 16'h030F,
                  16'h32A1, 16'h0000, 16'h32C1, 16'h0300, 16'h30A1, 16'h000E,
                  16'h2000, 16'h2000, 16'h2000, 16'h2000};

    vecs[0] = '{1'b0, 4'd2,  1'b0, 24'h0FC000};
    vecs[1] = '{1'b0, 4'd0,  1'b0, 24'h054000};
    vecs[2] = '{1'b0, 4'd9,  1'b1, 24'h000000};
    vecs[3] = '{1'b0, 4'd8,  1'b1, 24'h000000};
    vecs[4] = '{1'b0, 4'd7,  1'b0, 24'h2A0000};
    vecs[5] = '{1'b1, 4'd15, 1'b0, 24'h050000};
    vecs[6] = '{1'b1, 4'd0,  1'b0, 24'h150000};
    vecs[7] = '{1'b1, 4'd14, 1'b0, 24'hF50000};

    // Reset values, then holdoff with req held high on instance A.
    sel_b = 1'b0;
    req_a = 1'b1; slot_a = 4'd2;
    repeat (3) step();
    check("reset_flags", {28'd0, o_ready, o_busy, o_done, o_err}, 32'd0);
    check("reset_bus", {14'd0, o_ce_n, o_wr_n, o_din}, {14'd0, 2'b11, 16'hFFFF});
    rst_n = 1'b1;
    holdoff_check();
    step();
    req_a = 1'b0;
    expect_run(24'h0FC000, 1'b0);
    for (int k = 0; k < 16; k++)
      check($sformatf("slot2_literal%0d", k), {16'd0, got_q[k]}, {16'd0, rev_bytes(lit_slot2[k])});

    // Table-driven requests across both instances.
    for (int i = 0; i < 8; i++) begin
      sel_b = vecs[i].use_b;
      issue(vecs[i].slot);
      if (vecs[i].exp_err) expect_reject();
      else expect_run(vecs[i].exp_addr, 1'b0);
    end

    // Bit-swapped literal words for slot 0.
    sel_b = 1'b0;
    issue(4'd0);
    expect_run(24'h054000, 1'b0);
    check("swap_sync0", {16'd0, got_q[0]}, 32'h5599);
    check("swap_sync1", {16'd0, got_q[1]}, 32'hAA66);
    check("swap_gen1_data", {16'd0, got_q[3]}, 32'h0200);

    // Reset asserted right after word 6 is on the bus.
    sel_b = 1'b0;
    issue(4'd1);
    repeat (7) step();
    check("pre_reset_word6", {16'd0, o_din}, {16'd0, rev_bytes(16'h32A1)});
    #2 rst_n = 1'b0;
    #1;
    check("abort_bus", {14'd0, o_ce_n, o_wr_n, o_din}, {14'd0, 2'b11, 16'hFFFF});
    check("abort_flags", {28'd0, o_ready, o_busy, o_done, o_err}, 32'd0);
    step();
    rst_n = 1'b1;
    holdoff_check();
    issue(4'd1);
    expect_run(model_addr(1'b0, 1), 1'b0);

    // No-fallback build, 24-bit wrap, second request during busy ignored.
    sel_b = 1'b1;
    issue(4'd15);
    expect_run(24'h050000, 1'b1);
    check("nofb_gen1_data", {16'd0, got_q[3]}, 32'h0000);
    check("nofb_gen2_data", {16'd0, got_q[5]}, 32'h0305);
    step();
    check("busy_req_ignored", {31'd0, o_busy}, 32'd0);

    // Random requests against the model.
    for (int it = 0; it < 40; it++) begin
      sel_b = 1'($urandom_range(0, 1));
      s = 4'($urandom_range(0, 15));
      num = sel_b ? B_NUM : A_NUM;
      repeat ($urandom_range(0, 3)) step();
      issue(s);
      if (int'(s) >= num) expect_reject();
      else expect_run(model_addr(sel_b, int'(s)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic checkOutput();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
  endtask

  initial begin
    applyStimulus();
    checkOutput();
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

endmodule
